// File: rtl/addr_arb_pkg.sv
// Shared types and source indices for the address-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Requester index of each register source on the address bus
    localparam int REQ_PC     = 0;
    localparam int REQ_M      = 1;
    localparam int REQ_XY     = 2;
    localparam int REQ_J      = 3;
    localparam int N_ADDR_SRC = 4;

    // Largest count a CNT_W-bit down-counter can be loaded with
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first active requester searching upward from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_REQ-1:0] o_pick,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk offsets 1..N_REQ from the previous winner; the first hit wins
    always_comb begin
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!o_any && (i == (int'(i_last) + k) % N_REQ) && i_req[i]) begin
                    o_any     = 1'b1;
                    o_pick[i] = 1'b1;
                    o_idx     = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Address-bus arbiter: round-robin owner select with relay settle and break-before-make release.
// Latency: req sampled in IDLE drives sel on the same edge; bus_valid/gnt follow SETTLE_CYCLES edges later.
// Backpressure: requests are level-held; non-owners wait until IDLE. Build with ADDR_BUS_CONFLICT_CHECK_EN for load/select conflict flagging.
module addr_bus_arbiter
    import addr_arb_pkg::*;
#(
    parameter int N_REQ          = N_ADDR_SRC,
    parameter int SETTLE_CYCLES  = 3,
    parameter int RELEASE_CYCLES = 2,
    parameter int CNT_W          = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_load_req,
    output logic [N_REQ-1:0] o_sel,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_bus_valid,
    output logic             o_busy,
    output logic             o_conflict_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LD = CNT_W'((RELEASE_CYCLES > 0) ? RELEASE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(N_REQ - 1);

    if (N_REQ < 2) begin : g_bad_nreq
        $error("addr_bus_arbiter: N_REQ must be at least 2");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("addr_bus_arbiter: SETTLE_CYCLES out of range 1..15");
    end
    if (RELEASE_CYCLES < 0 || RELEASE_CYCLES > 15) begin : g_bad_release
        $error("addr_bus_arbiter: RELEASE_CYCLES out of range 0..15");
    end
    if (SETTLE_CYCLES - 1 > cnt_max(CNT_W) || RELEASE_CYCLES - 1 > cnt_max(CNT_W)) begin : g_bad_cntw
        $error("addr_bus_arbiter: CNT_W too narrow for the configured delays");
    end

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last;
    logic [N_REQ-1:0] r_sel;
    logic [N_REQ-1:0] r_gnt;
    logic             r_bus_valid;

    logic [N_REQ-1:0] w_pick;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_any;
    logic             w_own_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req  (i_req),
        .i_last (r_last),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_any)
    );

    assign w_own_req = i_req[r_owner];

    // Arbitration FSM: pick in IDLE, settle relays, hold for the owner, then enforce a dead time
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_owner     <= '0;
            r_last      <= LAST_RST;
            r_sel       <= '0;
            r_gnt       <= '0;
            r_bus_valid <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick_idx;
                        r_last  <= w_pick_idx;
                        r_sel   <= w_pick;
                        r_cnt   <= SETTLE_LD;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!w_own_req) begin
                        // Owner gave up before the bus settled: no grant, still honour dead time
                        r_sel <= '0;
                        if (RELEASE_CYCLES == 0) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= RELEASE_LD;
                            r_state <= RELEASE;
                        end
                    end else if (r_cnt == '0) begin
                        r_bus_valid <= 1'b1;
                        r_gnt       <= r_sel;
                        r_state     <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!w_own_req) begin
                        r_sel       <= '0;
                        r_bus_valid <= 1'b0;
                        if (RELEASE_CYCLES == 0) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= RELEASE_LD;
                            r_state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    // Requests deliberately ignored until the relays have opened
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ADDR_BUS_CONFLICT_CHECK_EN
    logic r_conflict;

    // Sticky flag: a register being loaded while it also drives the address bus
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_conflict <= 1'b0;
        end else begin
            if (|(r_sel & i_load_req)) begin
                r_conflict <= 1'b1;
                $error("addr_bus_arbiter: load and select of the same register (sel=%b load=%b)",
                       r_sel, i_load_req);
            end
        end
    end

    assign o_conflict_err = r_conflict;
`else
    logic w_unused_load;
    assign w_unused_load  = ^i_load_req;
    assign o_conflict_err = 1'b0;
`endif

    assign o_sel       = r_sel;
    assign o_gnt       = r_gnt;
    assign o_bus_valid = r_bus_valid;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Bench for addr_bus_arbiter: directed scenarios plus random requests against a timestamp model.
// Latency: model predicts outputs per edge from sel-start / release-deadline timestamps.
// Backpressure: n/a.
module tb_addr_bus_arbiter;

    localparam int N = 4;
    localparam int S = 3;
    localparam int R = 2;

    logic         i_clk;
    logic         i_reset;
    logic [N-1:0] i_req;
    logic [N-1:0] i_load_req;
    logic [N-1:0] o_sel;
    logic [N-1:0] o_gnt;
    logic         o_bus_valid;
    logic         o_busy;
    logic         o_conflict_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: who owns the bus, when its sel rose, and when arbitration reopens
    int m_owner    = -1;
    int m_start    = 0;
    int m_free_at  = 0;
    int m_last     = N - 1;
    bit m_conflict = 1'b0;
    int cyc        = 0;

    int zero_run   = 0;
    bit seen_sel   = 1'b0;
    logic [N-1:0] gnt_log[$];

    addr_bus_arbiter #(
        .N_REQ          (N),
        .SETTLE_CYCLES  (S),
        .RELEASE_CYCLES (R),
        .CNT_W          (4)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req          (i_req),
        .i_load_req     (i_load_req),
        .o_sel          (o_sel),
        .o_gnt          (o_gnt),
        .o_bus_valid    (o_bus_valid),
        .o_busy         (o_busy),
        .o_conflict_err (o_conflict_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare 1ns later
    task automatic step();
        logic [N-1:0] e_sel;
        logic [N-1:0] e_gnt;
        logic         e_bv;
        logic         e_busy;
        logic         rst_seen;
        @(posedge i_clk);
        cyc++;
        rst_seen = i_reset;
        if (i_reset) begin
            m_owner    = -1;
            m_last     = N - 1;
            m_free_at  = 0;
            m_conflict = 1'b0;
        end else begin
            if (m_owner >= 0 && i_load_req[m_owner]) m_conflict = 1'b1;
            if (m_owner >= 0) begin
                if (!i_req[m_owner]) begin
                    m_owner   = -1;
                    m_free_at = cyc + R + 1;
                end
            end else if (cyc >= m_free_at && i_req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && i_req[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_start = cyc;
                    end
                end
                if (m_owner >= 0) m_last = m_owner;
            end
        end
        #1;
        e_sel  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_bv   = (m_owner >= 0) && (cyc >= m_start + S);
        e_gnt  = ((m_owner >= 0) && (cyc == m_start + S)) ? e_sel : '0;
        e_busy = (m_owner >= 0) || (cyc < m_free_at - 1);
        chk("sel", 32'(o_sel), 32'(e_sel));
        chk("gnt", 32'(o_gnt), 32'(e_gnt));
        chk("bus_valid", 32'(o_bus_valid), 32'(e_bv));
        chk("busy", 32'(o_busy), 32'(e_busy));
        chk("sel_onehot", 32'($countones(o_sel) <= 1), 32'd1);
`ifdef ADDR_BUS_CONFLICT_CHECK_EN
        chk("conflict", 32'(o_conflict_err), 32'(m_conflict));
`else
        chk("conflict", 32'(o_conflict_err), 32'd0);
`endif
        if (o_gnt != '0) gnt_log.push_back(o_gnt);
        if (rst_seen) begin
            seen_sel = 1'b0;
            zero_run = 0;
        end else if (o_sel == '0) begin
            zero_run++;
        end else begin
            if (seen_sel && zero_run > 0) chk("bbm_gap", 32'(zero_run >= R + 1), 32'd1);
            seen_sel = 1'b1;
            zero_run = 0;
        end
    endtask

    task automatic wait_gnt(input string tag);
        int budget;
        budget = 40;
        while (budget > 0) begin
            step();
            if (o_gnt != '0) break;
            budget--;
        end
        if (budget == 0) chk(tag, 32'(o_gnt != '0), 32'd1);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
    endtask

    initial begin
        int gap;
        logic [N-1:0] exp_order[5];
        i_reset    = 1'b1;
        i_req      = '0;
        i_load_req = '0;
        step();
        i_reset = 1'b0;
        chk("rst_sel", 32'(o_sel), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        step();

        // Single request from M: sel on the sampling edge, valid+gnt three edges later
        i_req = 4'b0010;
        step();
        chk("t2_sel", 32'(o_sel), 32'h2);
        chk("t2_bv_early", 32'(o_bus_valid), 32'd0);
        step();
        step();
        step();
        chk("t2_gnt", 32'(o_gnt), 32'h2);
        chk("t2_bv", 32'(o_bus_valid), 32'd1);
        step();
        chk("t2_gnt_pulse", 32'(o_gnt), 32'd0);
        step();
        i_req = '0;
        step();
        chk("t2_sel_off", 32'(o_sel), 32'd0);
        chk("t2_bv_off", 32'(o_bus_valid), 32'd0);
        step();
        chk("t2_release", 32'(o_busy), 32'd1);
        step();
        chk("t2_idle", 32'(o_busy), 32'd0);

        // Reset while M holds the bus
        i_req = 4'b0010;
        wait_gnt("t1_gnt_timeout");
        step();
        do_reset();
        chk("t1_sel", 32'(o_sel), 32'd0);
        chk("t1_bv", 32'(o_bus_valid), 32'd0);
        chk("t1_busy", 32'(o_busy), 32'd0);

        // Contention: all request, owner drops after its grant; last=3 after reset so PC goes first
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        gnt_log.delete();
        i_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt("t3_gnt_timeout");
            i_req = 4'b1111 & ~o_gnt;
            step();
            i_req = 4'b1111;
        end
        chk("t3_count", 32'(gnt_log.size()), 32'd5);
        for (int g = 0; g < 5 && g < gnt_log.size(); g++) chk("t3_order", 32'(gnt_log[g]), 32'(exp_order[g]));
        i_req = '0;
        for (int c = 0; c < 8; c++) step();

        // Abort inside SETTLE: no grant, dead time still enforced
        i_req = 4'b0100;
        step();
        step();
        i_req = '0;
        step();
        chk("t4_sel", 32'(o_sel), 32'd0);
        chk("t4_gnt", 32'(o_gnt), 32'd0);
        chk("t4_busy", 32'(o_busy), 32'd1);
        step();
        step();
        chk("t4_idle", 32'(o_busy), 32'd0);

        // Break-before-make: PC releases while M waits; also load PC while it is selected
        do_reset();
        i_req = 4'b0001;
        wait_gnt("t5_gnt_timeout");
        i_load_req = 4'b0001;
        step();
        i_load_req = '0;
        i_req = 4'b0010;
        gap = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (o_sel == 4'b0010) break;
            if (o_sel == '0) gap++;
        end
        chk("t5_sel_m", 32'(o_sel), 32'h2);
        chk("t5_gap", 32'(gap >= R + 1), 32'd1);
`ifdef ADDR_BUS_CONFLICT_CHECK_EN
        chk("t6_conflict", 32'(o_conflict_err), 32'd1);
`else
        chk("t6_conflict", 32'(o_conflict_err), 32'd0);
`endif
        i_req = '0;
        for (int c = 0; c < 6; c++) step();
        do_reset();
        chk("t6_conflict_rst", 32'(o_conflict_err), 32'd0);

        // Random phase: bits toggle independently, occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) i_req[b] = ~i_req[b];
            end
`ifdef ADDR_BUS_CONFLICT_CHECK_EN
            i_load_req = '0;
`else
            i_load_req = N'($urandom_range(0, 15));
`endif
            i_reset = ($urandom_range(0, 199) == 0);
            step();
        end
        i_reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
